// File: rtl/rx_sync_ctrl_if.sv
// Serial settings bus bundle: address, data and one-cycle write strobe.
// The host side drives it; register blocks receive it.
interface rx_sync_ctrl_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;

  modport master (
    output serial_addr,
    output serial_data,
    output serial_strobe
  );

  modport slave (
    input serial_addr,
    input serial_data,
    input serial_strobe
  );
endinterface

// File: rtl/rx_sync_ctrl.sv
// Multi-board RX sync: master fires sync_out plus a delay-matched local
// sync_rx; slave regenerates sync_rx from the io-pin edge.
module rx_sync_ctrl #(
  parameter logic [6:0] SYNC_ADDR    = 7'd64,
  parameter int         MASTER_DELAY = 3,
  parameter int         HOLDOFF      = 16
) (
  input  logic         clock,
  input  logic         reset,
  rx_sync_ctrl_if.slave bus,
  input  logic         enable_rx,
  input  logic         rx_slave_sync,
  output logic         sync_out,
  output logic         sync_rx,
  output logic         armed,
  output logic [7:0]   sync_count
);

  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE, ARMED, PULSE, HOLD
  } state_t;

  state_t                  state;
  logic [1:0]              mode;
  logic [7:0]              plen;
  logic [7:0]              pcnt;
  logic [HW-1:0]           hcnt;
  logic                    s1, s2, s3;
  logic [MASTER_DELAY-1:0] dly;

  logic       wr;
  logic [1:0] mode_n;
  logic       master;
  logic       slave;
  logic       off;
  logic       arm;
  logic       rise;
  logic [7:0] plen_eff;
  logic       go_pulse;
  logic       unused_data;

  assign wr = bus.serial_strobe &&
              (bus.serial_addr == SYNC_ADDR);

  // A same-cycle mode write takes effect before arm/fire decisions.
  assign mode_n = wr ? bus.serial_data[1:0] : mode;
  assign master = (mode_n == 2'b01);
  assign slave  = (mode_n == 2'b10);
  assign off    = !(master || slave);
  assign arm    = wr && bus.serial_data[2];
  assign rise   = s2 && !s3;

  assign plen_eff = (plen == 8'd0) ? 8'd1 : plen;

  assign unused_data = ^{bus.serial_data[31:16],
                         bus.serial_data[7:3]};

  // High when the next registered state is PULSE.
  assign go_pulse = !off && (
    (state == ARMED &&
      (master ? enable_rx : rise)) ||
    (state == PULSE && pcnt != 8'd1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      mode       <= 2'b00;
      plen       <= 8'd1;
      pcnt       <= 8'd0;
      hcnt       <= '0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      dly        <= '0;
      sync_out   <= 1'b0;
      sync_rx    <= 1'b0;
      armed      <= 1'b0;
      sync_count <= 8'd0;
    end else begin
      s1 <= rx_slave_sync;
      s2 <= s1;
      s3 <= s2;
      if (wr) begin
        mode <= bus.serial_data[1:0];
        plen <= bus.serial_data[15:8];
      end
      sync_out <= master && go_pulse;
      // dly[0] mirrors sync_out; the tap adds the final register stage.
      dly <= MASTER_DELAY'({dly, master && go_pulse});
      sync_rx <= master ? dly[MASTER_DELAY-1]
                        : (slave && go_pulse);
      if (off) begin
        state   <= IDLE;
        armed   <= 1'b0;
        dly     <= '0;
        sync_rx <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (arm) begin
              state <= ARMED;
              armed <= 1'b1;
            end
          end
          ARMED: begin
            if (go_pulse) begin
              state <= PULSE;
              armed <= 1'b0;
              pcnt  <= plen_eff;
            end
          end
          PULSE: begin
            if (pcnt == 8'd1) begin
              state <= HOLD;
              hcnt  <= HW'(HOLDOFF);
            end else begin
              pcnt <= pcnt - 8'd1;
            end
          end
          HOLD: begin
            if (hcnt == HW'(1)) begin
              state      <= IDLE;
              sync_count <= sync_count + 8'd1;
            end else begin
              hcnt <= hcnt - HW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Directed bench for rx_sync_ctrl: dut a is driven from the bench,
// dut b is a slave fed by a's sync_out for the loopback check.
module tb_rx_sync_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable_rx = 1'b0;
  logic pin = 1'b0;

  logic       so_a, rx_a, armed_a;
  logic [7:0] cnt_a;
  logic       so_b, rx_b, armed_b;
  logic [7:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  rx_sync_ctrl_if bus_a ();
  rx_sync_ctrl_if bus_b ();

  rx_sync_ctrl u_a (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus_a),
    .enable_rx     (enable_rx),
    .rx_slave_sync (pin),
    .sync_out      (so_a),
    .sync_rx       (rx_a),
    .armed         (armed_a),
    .sync_count    (cnt_a)
  );

  rx_sync_ctrl u_b (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus_b),
    .enable_rx     (1'b0),
    .rx_slave_sync (so_a),
    .sync_out      (so_b),
    .sync_rx       (rx_b),
    .armed         (armed_b),
    .sync_count    (cnt_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic b,
                    input logic [6:0] addr,
                    input logic [31:0] data);
    if (b) begin
      bus_b.serial_addr   = addr;
      bus_b.serial_data   = data;
      bus_b.serial_strobe = 1'b1;
    end else begin
      bus_a.serial_addr   = addr;
      bus_a.serial_data   = data;
      bus_a.serial_strobe = 1'b1;
    end
    tick();
    bus_a.serial_strobe = 1'b0;
    bus_b.serial_strobe = 1'b0;
  endtask

  int hi;
  logic [7:0] p_so, p_rxa, p_rxb;

  initial begin
    bus_a.serial_addr   = 7'd0;
    bus_a.serial_data   = 32'd0;
    bus_a.serial_strobe = 1'b0;
    bus_b.serial_addr   = 7'd0;
    bus_b.serial_data   = 32'd0;
    bus_b.serial_strobe = 1'b0;

    tick();
    tick();
    chk("rst_so", so_a, 0);
    chk("rst_rx", rx_a, 0);
    chk("rst_armed", armed_a, 0);
    chk("rst_cnt", cnt_a, 0);
    reset = 1'b0;

    // slave: plen 4, 3-edge latency
    wr(0, 7'd64, 32'h0406);
    chk("slv_armed", armed_a, 1);
    pin = 1'b1;
    tick();
    chk("slv_lat0", rx_a, 0);
    tick();
    chk("slv_lat1", rx_a, 0);
    tick();
    chk("slv_rise", rx_a, 1);
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      hi += int'(rx_a);
    end
    chk("slv_len", hi, 3);
    tick();
    chk("slv_end", rx_a, 0);
    chk("slv_disarm", armed_a, 0);
    chk("slv_no_so", so_a, 0);

    // second rise during holdoff is dropped
    pin = 1'b0;
    repeat (3) tick();
    pin = 1'b1;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      hi += int'(rx_a);
    end
    chk("hold_drop", hi, 0);
    chk("cnt_pre", cnt_a, 0);
    tick();
    chk("cnt_one", cnt_a, 1);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      hi += int'(rx_a);
    end
    chk("oneshot", hi, 0);

    // re-arm then a fresh rise
    pin = 1'b0;
    repeat (3) tick();
    wr(0, 7'd64, 32'h0406);
    pin = 1'b1;
    for (int i = 0; i < 40 && cnt_a != 8'd2; i++)
      tick();
    chk("rearm_cnt", cnt_a, 2);
    pin = 1'b0;

    // master held off by enable_rx
    wr(0, 7'd64, 32'h0205);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      hi += int'(so_a);
    end
    chk("mst_wait_so", hi, 0);
    chk("mst_wait_armed", armed_a, 1);
    wr(1, 7'd64, 32'h0206);
    chk("b_armed", armed_b, 1);

    // enable: sync_out next edge, sync_rx 3 later, slave aligned
    enable_rx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      p_so[i]  = so_a;
      p_rxa[i] = rx_a;
      p_rxb[i] = rx_b;
    end
    chk("mst_so_pat", p_so, 8'b0000_0011);
    chk("mst_rx_pat", p_rxa, 8'b0001_1000);
    chk("loop_rx_pat", p_rxb, 8'b0001_1000);
    chk("mst_disarm", armed_a, 0);
    repeat (12) tick();
    chk("mst_cnt", cnt_a, 3);
    repeat (2) tick();
    chk("b_cnt", cnt_b, 1);
    chk("b_no_so", so_b, 0);
    enable_rx = 1'b0;

    // abort a long master pulse
    wr(0, 7'd64, 32'h0000_C805);
    enable_rx = 1'b1;
    repeat (2) tick();
    chk("abt_so_on", so_a, 1);
    repeat (3) tick();
    chk("abt_rx_on", rx_a, 1);
    wr(0, 7'd64, 32'h0000_0000);
    chk("abt_so_off", so_a, 0);
    chk("abt_rx_off", rx_a, 0);
    chk("abt_armed", armed_a, 0);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      hi += int'(rx_a | so_a);
    end
    chk("abt_flush", hi, 0);
    chk("abt_cnt", cnt_a, 3);
    enable_rx = 1'b0;

    // wrong address is ignored
    wr(0, 7'd63, 32'h0406);
    tick();
    chk("addr63", armed_a, 0);

    // reset in the middle of a slave pulse
    wr(0, 7'd64, 32'h0000_C806);
    pin = 1'b1;
    repeat (3) tick();
    chk("rstm_rx_on", rx_a, 1);
    reset = 1'b1;
    tick();
    chk("rstm_rx", rx_a, 0);
    chk("rstm_so", so_a, 0);
    chk("rstm_cnt", cnt_a, 0);
    reset = 1'b0;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      hi += int'(rx_a | so_a);
    end
    chk("rstm_quiet", hi, 0);

    // plen 0 behaves as a single cycle
    pin = 1'b0;
    repeat (3) tick();
    wr(0, 7'd64, 32'h0006);
    pin = 1'b1;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      hi += int'(rx_a);
    end
    chk("plen0_len", hi, 1);
    pin = 1'b0;

    // 256 master syncs wrap the counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    enable_rx = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      wr(0, 7'd64, 32'h0005);
      repeat (20) tick();
      if (n == 255)
        chk("cnt_255", cnt_a, 255);
    end
    chk("cnt_wrap", cnt_a, 0);
    enable_rx = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
